// File: rtl/ltc2333_sequencer.sv
// ltc2333_sequencer: slot-table conversion scheduler for the LTC2333 write engine with readout tagging.
// Optional LTC2333_SEQ_OVERRUN_COUNT_EN enables the saturating overrun_cnt counter.
module ltc2333_sequencer #(
    parameter int NUM_SLOTS    = 16,
    parameter int CW_WIDTH     = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = 32,
    localparam int AW = $clog2(NUM_SLOTS),
    localparam int LW = AW + 1
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [LW-1:0]           seq_len,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [CW_WIDTH-1:0]     cfg_wdata,
    output logic                    cmd_valid,
    output logic [CW_WIDTH-1:0]     cmd_word,
    input  logic                    cmd_ready,
    input  logic                    cmd_done,
    output logic                    tag_valid,
    output logic [AW-1:0]           tag_slot,
    output logic                    active,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic [15:0]             overrun_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_TICK, ISSUE, WAIT_DONE} state_t;
    state_t                  state_q;
    logic [CW_WIDTH-1:0]     tbl_q [NUM_SLOTS];
    logic [CW_WIDTH-1:0]     cmd_word_q;
    logic [AW-1:0]           idx_q, issued_q, prev_slot_q, tag_slot_q, idx_d;
    logic [LW-1:0]           len_q, len_d;
    logic [PERIOD_WIDTH-1:0] per_q, per_d, timer_q;
    logic                    prev_valid_q, cmd_valid_q, tag_valid_q, overrun_q;
    logic                    tick, drop, wrap;
    always_comb begin
        len_d = seq_len == '0 ? LW'(1) : seq_len > LW'(NUM_SLOTS) ? LW'(NUM_SLOTS) : seq_len;
        per_d = period < PERIOD_WIDTH'(MIN_PERIOD) ? PERIOD_WIDTH'(MIN_PERIOD) : period;
        tick  = state_q != IDLE && timer_q == '0;
        drop  = tick && (state_q == ISSUE || state_q == WAIT_DONE);
        wrap  = {1'b0, idx_q} == len_q - LW'(1);
        idx_d = wrap ? '0 : idx_q + AW'(1);
    end
    // Table has no reset; a write racing a read leaves the old word in cmd_word_q.
    always_ff @(posedge clk)
        if (cfg_we) tbl_q[cfg_addr] <= cfg_wdata;
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            cmd_word_q   <= '0;
            idx_q        <= '0;
            issued_q     <= '0;
            prev_slot_q  <= '0;
            tag_slot_q   <= '0;
            len_q        <= LW'(1);
            per_q        <= '0;
            timer_q      <= '0;
            prev_valid_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            tag_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            tag_valid_q <= 1'b0;
            overrun_q   <= drop ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;
            // Timer free-runs outside IDLE so ticks stay on a fixed grid.
            timer_q     <= state_q == IDLE ? (enable ? per_d - 1'b1 : '0)
                         : tick ? per_q - 1'b1 : timer_q - 1'b1;
            case (state_q)
                IDLE: if (enable) begin
                    state_q <= WAIT_TICK;
                    len_q   <= len_d;
                    per_q   <= per_d;
                end
                WAIT_TICK: if (!enable) begin
                    state_q      <= IDLE;
                    idx_q        <= '0;
                    prev_valid_q <= 1'b0;
                end else if (tick) begin
                    state_q     <= ISSUE;
                    cmd_word_q  <= tbl_q[idx_q];
                    cmd_valid_q <= 1'b1;
                end
                ISSUE: if (cmd_ready) begin
                    state_q     <= WAIT_DONE;
                    cmd_valid_q <= 1'b0;
                    issued_q    <= idx_q;
                    idx_q       <= idx_d;
                    if (wrap) begin
                        len_q <= len_d;
                        per_q <= per_d;
                    end
                end
                WAIT_DONE: if (cmd_done) begin
                    tag_valid_q  <= prev_valid_q;
                    tag_slot_q   <= prev_slot_q;
                    prev_slot_q  <= issued_q;
                    prev_valid_q <= enable;
                    state_q      <= enable ? WAIT_TICK : IDLE;
                    if (!enable) idx_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef LTC2333_SEQ_OVERRUN_COUNT_EN
    logic [15:0] cnt_q, cnt_base, cnt_d;
    always_comb begin
        cnt_base = overrun_clr ? '0 : cnt_q;
        cnt_d    = cnt_base + 16'(drop && cnt_base != '1);
    end
    always_ff @(posedge clk or posedge areset)
        if (areset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign overrun_cnt = cnt_q;
`else
    assign overrun_cnt = '0;
`endif
    assign cmd_valid = cmd_valid_q;
    assign cmd_word  = cmd_word_q;
    assign tag_valid = tag_valid_q;
    assign tag_slot  = tag_slot_q;
    assign active    = state_q != IDLE;
    assign overrun   = overrun_q;
endmodule
